// File: rtl/token_batch_drain.sv
// Coalesces tokens popped from a count-only upstream FIFO into batches.
// A batch closes when full or after an idle timeout and is handed off on valid/ready.
module token_batch_drain #(
  parameter int p1maxbatch  = 8,
  parameter int p2cnt_width = 4,
  parameter int p3timeout   = 16,
  parameter int p4tmr_width = 5
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   CLR,
  input  logic                   FIFO_EMPTY_N,
  output logic                   FIFO_DEQ,
  output logic                   BATCH_VALID,
  input  logic                   BATCH_READY,
  output logic [p2cnt_width-1:0] BATCH_COUNT,
  output logic                   BATCH_TIMEOUT
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_PRESENT = 2'd2
  } state_t;

  localparam logic [p2cnt_width-1:0] MAX_C      = p2cnt_width'(p1maxbatch);
  localparam logic [p2cnt_width-1:0] CNT_ZERO_C = {p2cnt_width{1'b0}};
  localparam logic [p2cnt_width-1:0] CNT_ONE_C  = p2cnt_width'(1);
  localparam logic [p4tmr_width-1:0] TMR_ZERO_C = {p4tmr_width{1'b0}};
  localparam logic [p4tmr_width-1:0] TMR_ONE_C  = p4tmr_width'(1);
  localparam logic [p4tmr_width-1:0] TMR_LAST_C = p4tmr_width'(p3timeout - 1);

  state_t                   state_q,   state_d;
  logic [p2cnt_width-1:0]   count_q,   count_d;
  logic [p4tmr_width-1:0]   timer_q,   timer_d;
  logic                     valid_q,   valid_d;
  logic [p2cnt_width-1:0]   bcount_q,  bcount_d;
  logic                     tout_q,    tout_d;
  logic                     deq_s;
  logic [p2cnt_width-1:0]   count_inc_s;

  // Pop gating is independent of BATCH_READY so no ready-to-deq path exists.
  assign deq_s = !RST && !CLR && FIFO_EMPTY_N &&
                 ((state_q == S_IDLE) || (state_q == S_COLLECT)) &&
                 (count_q < MAX_C);
  assign count_inc_s = count_q + CNT_ONE_C;

  assign FIFO_DEQ      = deq_s;
  assign BATCH_VALID   = valid_q;
  assign BATCH_COUNT   = bcount_q;
  assign BATCH_TIMEOUT = tout_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    timer_d  = timer_q;
    valid_d  = valid_q;
    bcount_d = bcount_q;
    tout_d   = tout_q;
    if (CLR) begin
      state_d = S_IDLE;
      count_d = CNT_ZERO_C;
      timer_d = TMR_ZERO_C;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          timer_d = TMR_ZERO_C;
          if (deq_s) begin
            count_d = CNT_ONE_C;
            if (p1maxbatch == 1) begin
              state_d  = S_PRESENT;
              valid_d  = 1'b1;
              bcount_d = CNT_ONE_C;
              tout_d   = 1'b0;
            end else begin
              state_d = S_COLLECT;
            end
          end else begin
            count_d = CNT_ZERO_C;
          end
        end
        S_COLLECT: begin
          if (deq_s) begin
            count_d = count_inc_s;
            timer_d = TMR_ZERO_C;
            if (count_inc_s == MAX_C) begin
              state_d  = S_PRESENT;
              valid_d  = 1'b1;
              bcount_d = count_inc_s;
              tout_d   = 1'b0;
            end else begin
              state_d = S_COLLECT;
            end
          end else if (timer_q == TMR_LAST_C) begin
            // Timer holds at its last value; it is cleared on accept.
            state_d  = S_PRESENT;
            valid_d  = 1'b1;
            bcount_d = count_q;
            tout_d   = 1'b1;
          end else begin
            timer_d = timer_q + TMR_ONE_C;
          end
        end
        S_PRESENT: begin
          if (BATCH_READY) begin
            state_d = S_IDLE;
            count_d = CNT_ZERO_C;
            timer_d = TMR_ZERO_C;
            valid_d = 1'b0;
          end else begin
            state_d = S_PRESENT;
          end
        end
        default: begin
          state_d = S_IDLE;
          count_d = CNT_ZERO_C;
          timer_d = TMR_ZERO_C;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      count_q  <= CNT_ZERO_C;
      timer_q  <= TMR_ZERO_C;
      valid_q  <= 1'b0;
      bcount_q <= CNT_ZERO_C;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      timer_q  <= timer_d;
      valid_q  <= valid_d;
      bcount_q <= bcount_d;
      tout_q   <= tout_d;
    end
  end

endmodule
